rho_inv_seq: RTL

Sequential inverse of the Keccak rho step. The block latches a full 5x5 lane state and, over 24 cycles, rotates each non-origin lane **right** by its rho offset, one lane per cycle. This undoes the left rotations applied by the forward rho stage. It sits beside the Shake permutation datapath and is used for inverse-permutation checking and state recovery, with a start/busy/done handshake toward the controlling FSM.

---
 rtl/rho_inv_seq.sv | 137 +++++++++++++
 1 files changed

// File: rtl/rho_inv_seq.sv
// -----------------------------------------------------------------------------
// rho_inv_seq
//
// Sequential inverse of the Keccak rho step. A full 5x5 lane state is latched
// on start. Over the next 24 cycles each non-origin lane is rotated right by
// its rho offset, one lane per cycle. This undoes the left rotations applied by
// the forward rho stage. Lane [0][0] is never modified.
//
// Ports
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset
//   start  : request to process A_in, accepted only while idle
//   A_in   : input state, indexed A_in[x][y], 64-bit lanes
//   A_out  : internal state register, driven continuously; valid when done=1
//   busy   : high while lanes are being rotated
//   done   : one-cycle pulse when A_out holds the finished result
// -----------------------------------------------------------------------------
module rho_inv_seq (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [0:4][0:4][63:0] A_in,
  output logic [0:4][0:4][63:0] A_out,
  output logic                  busy,
  output logic                  done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [0:4][0:4][63:0]  st_q, st_d;
  logic [4:0]             t_q, t_d;
  logic [2:0]             x_q, x_d;
  logic [2:0]             y_q, y_d;
  logic [5:0]             off_q, off_d;

  logic [63:0]            lane;
  logic [63:0]            laneRot;
  logic [4:0]             ySum;

  // Rotate the lane at the current walk position right by the running offset.
  // The left-shift amount is 64 - off in 7 bits, so an offset of zero shifts
  // the left term out completely and the lane passes through unchanged.
  always_comb begin
    lane    = st_q[x_q][y_q];
    laneRot = (lane >> off_q) | (lane << (7'd64 - {1'b0, off_q}));
  end

  // Walk the lane positions as (x,y) -> (y, 2x + 3y mod 5). The sum never
  // exceeds 20, so the modulo reduction is a small lookup table.
  always_comb begin
    ySum = {1'b0, x_q, 1'b0} + {2'b00, y_q} + {1'b0, y_q, 1'b0};
    case (ySum)
      5'd0, 5'd5, 5'd10, 5'd15, 5'd20: y_d = 3'd0;
      5'd1, 5'd6, 5'd11, 5'd16:        y_d = 3'd1;
      5'd2, 5'd7, 5'd12, 5'd17:        y_d = 3'd2;
      5'd3, 5'd8, 5'd13, 5'd18:        y_d = 3'd3;
      5'd4, 5'd9, 5'd14, 5'd19:        y_d = 3'd4;
      default:                         y_d = 3'd0;
    endcase
  end

  // Controller and datapath next-state. Only one lane is written per RUN
  // cycle; every other lane holds. The offset is a 6-bit accumulator that
  // adds t+2 each step, giving the triangular numbers mod 64.
  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    t_d     = t_q;
    x_d     = x_q;
    off_d   = off_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          st_d    = A_in;
          t_d     = 5'd0;
          x_d     = 3'd1;
          off_d   = 6'd1;
          state_d = RUN;
        end
      end
      RUN: begin
        st_d[x_q][y_q] = laneRot;
        x_d            = y_q;
        off_d          = off_q + {1'b0, t_q} + 6'd2;
        t_d            = t_q + 5'd1;
        if (t_q == 5'd23) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The y coordinate only advances during RUN and is reloaded on start; the
  // table output above is used only in RUN.
  logic [2:0] yNext;
  always_comb begin
    yNext = y_q;
    if (state_q == IDLE && start) begin
      yNext = 3'd0;
    end else if (state_q == RUN) begin
      yNext = y_d;
    end
  end

  // State registers with asynchronous clear to the idle configuration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      st_q    <= '0;
      t_q     <= 5'd0;
      x_q     <= 3'd1;
      y_q     <= 3'd0;
      off_q   <= 6'd1;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      t_q     <= t_d;
      x_q     <= x_d;
      y_q     <= yNext;
      off_q   <= off_d;
    end
  end

  assign A_out = st_q;
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);

endmodule
